// File: rtl/reg_share_arbiter_pkg.sv
// Shared types and helpers for the shared-register round-robin arbiter.
// Latency: n/a (types/functions only). Backpressure: n/a.
// Contents: FSM state enum, default sizing, one-hot to index conversion.
package reg_share_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_W = 8;

    // LOCKED is only reachable when REG_SHARE_LOCK_EN is defined.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Index of the set bit of a one-hot vector (up to 16 requesters).
    function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/reg_share_arbiter_if.sv
// Bundle of request/data/grant and shared-register outputs of the arbiter.
// Latency: n/a (wiring only). Backpressure: req held until gnt is seen.
// Ports: req, wdata, gnt, q, q_owner, q_upd, busy; lock when REG_SHARE_LOCK_EN.
interface reg_share_arbiter_if #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int IW = $clog2(N)
);
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
`ifdef REG_SHARE_LOCK_EN
    logic [N-1:0]   lock;
`endif
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic [IW-1:0]  q_owner;
    logic           q_upd;
    logic           busy;

    modport master (
`ifdef REG_SHARE_LOCK_EN
        output lock,
`endif
        output req, wdata,
        input  gnt, q, q_owner, q_upd, busy
    );

    modport slave (
`ifdef REG_SHARE_LOCK_EN
        input  lock,
`endif
        input  req, wdata,
        output gnt, q, q_owner, q_upd, busy
    );
endinterface

// File: rtl/reg_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req_vec scanning from ptr upward, wrapping.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: req_vec[N], ptr[IW] in; any, winner[N] (one-hot) out.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_vec,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [N-1:0]  winner
);
    logic found;
    int   j;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        j      = 0;
        any    = |req_vec;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!found && req_vec[j]) begin
                winner[j] = 1'b1;
                found     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter writing one granted requester's data per cycle into a shared W-bit register.
// Latency: req -> gnt 1 cycle, gnt -> q/q_upd 1 cycle; one grant per cycle with >=2 active requesters.
// Backpressure: requesters hold req+data until gnt; optional REG_SHARE_LOCK_EN adds lock to hold a grant.
// Ports: clk, reset (async active-high), bus (slave modport of reg_share_arbiter_if).
module reg_share_arbiter
    import reg_share_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int W  = DEF_W,
    parameter int IW = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    reg_share_arbiter_if.slave bus
);
    state_t        state, state_nxt;
    logic [N-1:0]  gnt_r, gnt_nxt;
    logic [N-1:0]  eff_req, pick_win;
    logic          pick_any;
    logic [IW-1:0] ptr, ptr_nxt, pick_ptr, ptr_adv, gnt_idx;
    logic          wr_en;
    logic          lock_cur;
    logic [W-1:0]  q_r;
    logic [IW-1:0] q_owner_r;
    logic          q_upd_r;

    assign gnt_idx = IW'(onehot_to_idx(16'(gnt_r)));
    assign ptr_adv = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;

`ifdef REG_SHARE_LOCK_EN
    assign lock_cur = bus.lock[gnt_idx];
`else
    assign lock_cur = 1'b0;
`endif

    // While granting, the current grantee still shows req, so it is masked out
    // and the next winner is searched from the pointer just past it.
    always_comb begin
        eff_req  = bus.req;
        pick_ptr = ptr;
        if (state != IDLE) begin
            eff_req  = bus.req & ~gnt_r;
            pick_ptr = ptr_adv;
        end
    end

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req_vec (eff_req),
        .ptr     (pick_ptr),
        .any     (pick_any),
        .winner  (pick_win)
    );

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_r;
        ptr_nxt   = ptr;
        wr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    gnt_nxt   = pick_win;
                    state_nxt = GRANT;
                end
            end
`ifdef REG_SHARE_LOCK_EN
            GRANT, LOCKED: begin
`else
            GRANT: begin
`endif
                wr_en = 1'b1;
                if (lock_cur) begin
                    state_nxt = LOCKED;
                end else begin
                    ptr_nxt = ptr_adv;
                    if (pick_any) begin
                        gnt_nxt   = pick_win;
                        state_nxt = GRANT;
                    end else begin
                        gnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gnt_r     <= '0;
            ptr       <= '0;
            q_r       <= '0;
            q_owner_r <= '0;
            q_upd_r   <= 1'b0;
        end else begin
            state   <= state_nxt;
            gnt_r   <= gnt_nxt;
            ptr     <= ptr_nxt;
            q_upd_r <= wr_en;
            if (wr_en) begin
                q_r       <= bus.wdata[int'(gnt_idx) * W +: W];
                q_owner_r <= gnt_idx;
            end
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.q       = q_r;
    assign bus.q_owner = q_owner_r;
    assign bus.q_upd   = q_upd_r;
    assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter (N=4, W=8); lock scenario included when REG_SHARE_LOCK_EN is defined.
// Latency: n/a. Backpressure: requesters drop req right after seeing their grant.
// Drives the master side of reg_share_arbiter_if; all expected values are hand-computed constants.
module tb_reg_share_arbiter;
    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   upd_cnt;

    reg_share_arbiter_if #(.N(4), .W(8)) bus ();

    reg_share_arbiter #(.N(4), .W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        upd_cnt = 0;
        reset   = 1'b1;
        bus.req   = 4'b1111;
        bus.wdata = {8'h13, 8'h12, 8'h11, 8'h10};
`ifdef REG_SHARE_LOCK_EN
        bus.lock  = 4'b0000;
`endif
        // Reset held 20 ns with all requesting
        #1;
        check("rst_gnt_a", 32'(bus.gnt), 32'h0);
        check("rst_q_a", 32'(bus.q), 32'h0);
        check("rst_busy_a", 32'(bus.busy), 32'h0);
        #15;
        check("rst_gnt_b", 32'(bus.gnt), 32'h0);
        check("rst_q_b", 32'(bus.q), 32'h0);
        check("rst_upd_b", 32'(bus.q_upd), 32'h0);
        check("rst_owner_b", 32'(bus.q_owner), 32'h0);
        #4 reset = 1'b0;

        // All four requesting continuously: rotation from ptr=0
        step;
        check("rr_gnt0", 32'(bus.gnt), 32'h1);
        check("rr_busy0", 32'(bus.busy), 32'h1);
        check("rr_upd0", 32'(bus.q_upd), 32'h0);
        step;
        check("rr_gnt1", 32'(bus.gnt), 32'h2);
        check("rr_q1", 32'(bus.q), 32'h10);
        check("rr_own1", 32'(bus.q_owner), 32'h0);
        check("rr_upd1", 32'(bus.q_upd), 32'h1);
        step;
        check("rr_gnt2", 32'(bus.gnt), 32'h4);
        check("rr_q2", 32'(bus.q), 32'h11);
        check("rr_own2", 32'(bus.q_owner), 32'h1);
        check("rr_upd2", 32'(bus.q_upd), 32'h1);
        step;
        check("rr_gnt3", 32'(bus.gnt), 32'h8);
        check("rr_q3", 32'(bus.q), 32'h12);
        check("rr_own3", 32'(bus.q_owner), 32'h2);
        step;
        check("rr_gnt4", 32'(bus.gnt), 32'h1);
        check("rr_q4", 32'(bus.q), 32'h13);
        check("rr_own4", 32'(bus.q_owner), 32'h3);
        check("rr_upd4", 32'(bus.q_upd), 32'h1);
        bus.req = 4'b0000;
        step;
        check("rr_gnt_end", 32'(bus.gnt), 32'h0);
        check("rr_q_end", 32'(bus.q), 32'h10);
        check("rr_own_end", 32'(bus.q_owner), 32'h0);
        check("rr_busy_end", 32'(bus.busy), 32'h0);
        step;
        check("hold_upd", 32'(bus.q_upd), 32'h0);
        check("hold_q", 32'(bus.q), 32'h10);

        // Single requester 2 with A5 (ptr=1 now)
        bus.wdata[23:16] = 8'hA5;
        bus.req = 4'b0100;
        step;
        check("single_gnt", 32'(bus.gnt), 32'h4);
        check("single_upd0", 32'(bus.q_upd), 32'h0);
        bus.req = 4'b0000;
        step;
        check("single_q", 32'(bus.q), 32'hA5);
        check("single_own", 32'(bus.q_owner), 32'h2);
        check("single_upd", 32'(bus.q_upd), 32'h1);
        check("single_gnt_off", 32'(bus.gnt), 32'h0);
        check("single_busy", 32'(bus.busy), 32'h0);
        step;
        check("single_idle_upd", 32'(bus.q_upd), 32'h0);
        check("single_idle_gnt", 32'(bus.gnt), 32'h0);

        // Wrap-around: ptr=3, requesters 3 and 0
        bus.wdata[31:24] = 8'h3C;
        bus.req = 4'b1001;
        step;
        check("wrap_gnt3", 32'(bus.gnt), 32'h8);
        bus.req = 4'b0001;
        step;
        check("wrap_gnt0", 32'(bus.gnt), 32'h1);
        check("wrap_q3", 32'(bus.q), 32'h3C);
        check("wrap_own3", 32'(bus.q_owner), 32'h3);
        bus.req = 4'b0000;
        step;
        check("wrap_q0", 32'(bus.q), 32'h10);
        check("wrap_own0", 32'(bus.q_owner), 32'h0);
        check("wrap_idle", 32'(bus.gnt), 32'h0);

        // Async reset in the middle of a grant (ptr=1 -> requester 1 granted)
        bus.req = 4'b0011;
        step;
        check("mid_gnt", 32'(bus.gnt), 32'h2);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_gnt", 32'(bus.gnt), 32'h0);
        check("mid_rst_q", 32'(bus.q), 32'h0);
        check("mid_rst_busy", 32'(bus.busy), 32'h0);
        check("mid_rst_upd", 32'(bus.q_upd), 32'h0);
        step;
        check("mid_rst_noupd", 32'(bus.q_upd), 32'h0);
        check("mid_rst_noq", 32'(bus.q), 32'h0);
        #2 reset = 1'b0;
        step;
        check("mid_restart_gnt", 32'(bus.gnt), 32'h1);
        bus.req = 4'b0000;
        step;
        check("mid_restart_q", 32'(bus.q), 32'h10);
        check("mid_restart_gnt_off", 32'(bus.gnt), 32'h0);

`ifdef REG_SHARE_LOCK_EN
        // Lock held by requester 1 for three grant cycles (ptr=1)
        bus.req = 4'b0011;
        step;
        check("lock_gnt_first", 32'(bus.gnt), 32'h2);
        bus.lock = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            step;
            check("lock_gnt_hold", 32'(bus.gnt), 32'h2);
            upd_cnt += int'(bus.q_upd);
            if (k == 2) bus.lock = 4'b0000;
        end
        step;
        upd_cnt += int'(bus.q_upd);
        check("lock_gnt_next", 32'(bus.gnt), 32'h1);
        check("lock_upd_cnt", 32'(upd_cnt), 32'd4);
        check("lock_q", 32'(bus.q), 32'h11);
        check("lock_own", 32'(bus.q_owner), 32'h1);
        bus.req = 4'b0000;
        step;
        check("lock_final_q", 32'(bus.q), 32'h10);
        check("lock_final_gnt", 32'(bus.gnt), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_share_arbiter.md
Name: reg_share_arbiter

Overview:
- Round-robin arbiter that shares one W-bit storage register (a bank of D flip-flops) between N requesters.
- Each requester raises req with its data. The arbiter grants one requester per cycle and writes that requester's data into the shared register.
- It publishes the register value, the index of the last writer and a one-cycle update strobe.
- Sits between several producer blocks and a single shared configuration/status register.

Parameters:
- N, 4: number of requesters, 2..16.
- W, 8: data width of the shared register.
- IW, $clog2(N): owner index width; derived, not to be overridden.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  N  request per requester. Held high with stable data until gnt is seen.
- wdata  input  N*W  packed data; requester i occupies bits [i*W +: W].
- gnt  output  N  registered one-hot grant, asserted for one cycle per transfer.
- q  output  W  shared register contents.
- q_owner  output  IW  index of the requester that last wrote q.
- q_upd  output  1  one-cycle pulse, high in the cycle q shows new data.
- busy  output  1  high while state is not IDLE.

Behaviour:
- Reset (async, immediate):
  - gnt=0, q=0, q_owner=0, q_upd=0, busy=0.
  - Round-robin pointer ptr=0; state=IDLE.
- Arbitration (combinational, every cycle): winner = first set bit of the effective request vector, scanning from ptr upward with wrap N-1→0.
- Effective request vector:
  - In IDLE: req.
  - In GRANT: req & ~gnt. The currently granted requester is masked because its req is still high this cycle.
- FSM states IDLE, GRANT (plus LOCKED if the optional feature is enabled):
  - IDLE: if any effective req, set gnt=onehot(winner) at the next edge and go to GRANT; otherwise stay.
  - GRANT: at the edge ending this cycle:
    - q←wdata[idx(gnt)], q_owner←idx(gnt), q_upd=1 in the following cycle.
    - ptr←(idx(gnt)+1) mod N.
    - If another effective req exists, grant its winner (computed from the updated ptr) and stay in GRANT; otherwise gnt=0 and go to IDLE.
- Latency:
  - req rising at edge t → gnt high in cycle t+1.
  - q/q_upd valid in cycle t+2.
  - Sustained throughput is one grant per cycle when at least 2 requesters are active.
- Same requester is never granted two consecutive cycles (unless the optional lock is used). A requester must drop req the cycle after its gnt; a req still high one cycle later is treated as a new request.
- Single requester repeatedly requesting: grants in alternate cycles (GRANT→IDLE→GRANT).
- All N requesting: grants in order ptr, ptr+1, …, wrapping; no starvation, with a worst-case wait of N grant cycles.
- req dropped before its gnt: no grant, no write; withdrawal is legal.
- Reset mid-transfer: the pending write is discarded; q returns to 0.
- q holds its value indefinitely between writes; q_upd is low when there is no write.

Optional Feature:
- Macro: REG_SHARE_LOCK_EN.
- Defined:
  - Adds input lock[N-1:0].
  - If lock[idx(gnt)] is high in a GRANT cycle, go to LOCKED and keep gnt unchanged. Each cycle in LOCKED writes wdata of that requester, with q_upd=1 per write.
  - When lock drops, perform the final write, advance ptr and re-arbitrate as in GRANT.
  - Reset clears LOCKED.
- Undefined: no lock port; LOCKED state is absent; behaviour as described above.

Decomposition:
- Package reg_share_pkg:
  - state enum (IDLE, GRANT, LOCKED).
  - Default N and W localparams.
  - onehot-to-index function.
- Sub-module rr_pick: purely combinational round-robin picker with inputs req_vec[N] and ptr[IW], outputs any and winner one-hot. It is instantiated once; the FSM and registers stay in reg_share_arbiter.

Test Plan:
- Reset held 20 ns with req=4'b1111 → gnt=0, q=0, busy=0 throughout; first gnt=4'b0001 one cycle after reset release.
- req[2]=1, wdata[2]=8'hA5 at edge t, dropped after gnt → gnt=4'b0100 in cycle t+1; q=8'hA5, q_owner=2, q_upd=1 in cycle t+2; idle afterwards.
- req=4'b1111 held continuously with distinct data 8'h10..8'h13 → gnt sequence 0001,0010,0100,1000,0001; one q_upd per cycle; q_owner 0,1,2,3,0.
- ptr=3 after previous grant, req=4'b1001 → gnt[3] first then gnt[0]; confirms wrap-around.
- Async reset asserted mid-GRANT (req=4'b0011) → outputs clear immediately, no q_upd, and the next grant starts from ptr=0.
- REG_SHARE_LOCK_EN defined: lock[1]=1 for 3 cycles with req=4'b0011 → gnt=4'b0010 held 4 cycles, 4 q_upd pulses, then gnt=4'b0001.
